// File: rtl/mul_shift_add_8_pkg.sv
// mul_shift_add_8_pkg: shared width constant and FSM state encoding for the multiplier
package mul_shift_add_8_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul_shift_add_8_if.sv
// mul_shift_add_8_if: start/busy/done request bus carrying operands and product
interface mul_shift_add_8_if;
    import mul_shift_add_8_pkg::*;
    logic                  start;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  busy;
    logic                  done;
    logic [2*DATA_W-1:0]   product;
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul_shift_add_8_rca.sv
// add_rca_8: 8-bit ripple-carry adder with carry in and carry out
module add_rca_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);
    logic [8:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign c_out = c[8];
endmodule

// File: rtl/mul_shift_add_8.sv
// mul_shift_add_8: iterative 8x8 unsigned shift-and-add multiplier driving one add_rca_8 per cycle
module mul_shift_add_8
    import mul_shift_add_8_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    mul_shift_add_8_if.slave bus
);
    if (WIDTH != 8) begin : g_bad_width
        $fatal(1, "mul_shift_add_8: WIDTH must be 8 to match add_rca_8");
    end
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   sum;
    logic               c_out;
    logic [2*WIDTH-1:0] shifted;
    add_rca_8 u_add (
        .a     (acc_hi_q),
        .b     (acc_lo_q[0] ? mcand_q : '0),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );
    // carry out becomes the new top bit so the 17-bit partial sum is never truncated
    assign shifted = {c_out, sum, acc_lo_q[WIDTH-1:1]};
    always_comb begin
        state_d   = S_IDLE;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    mcand_d  = bus.a;
                    acc_lo_d = bus.b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                {acc_hi_d, acc_lo_d} = shifted;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? S_DONE : S_RUN;
                if (cnt_q == CNT_W'(WIDTH - 1)) product_d = shifted;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
        end
    end
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_mul_shift_add_8.sv
// tb_mul_shift_add_8: scoreboard-driven scenario tests for the shift-and-add multiplier
module tb_mul_shift_add_8;
    logic clk;
    logic rst;
    int passed;
    int total;
    logic [15:0] exp_q[$];
    mul_shift_add_8_if bus ();
    mul_shift_add_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit push);
        @(negedge clk);
        bus.start = 1;
        bus.a = a;
        bus.b = b;
        if (push) exp_q.push_back(16'(a) * 16'(b));
        @(negedge clk);
        bus.start = 0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask
    task automatic collect(output bit found, output logic [15:0] got, output int busy_cycles, output logic busy_at_done);
        found = 0;
        got = 'x;
        busy_cycles = 0;
        busy_at_done = 'x;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                found = 1;
                got = bus.product;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
    endtask
    task automatic test_reset;
        rst = 1;
        bus.start = 0;
        bus.a = 0;
        bus.b = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        total++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        total++;
        if (bus.product !== 16'h0000) $display("FAIL reset_product: got %h want 0000", bus.product); else passed++;
    endtask
    task automatic run_and_check(input string name, input logic [7:0] a, input logic [7:0] b);
        bit found;
        logic [15:0] got, exp;
        int bc;
        logic bd;
        launch(a, b, 1);
        collect(found, got, bc, bd);
        exp = exp_q.pop_front();
        total++;
        if (!found) $display("FAIL %s_done: no done pulse within bound", name); else passed++;
        total++;
        if (got !== exp) $display("FAIL %s_product: got %h want %h", name, got, exp); else passed++;
        total++;
        if (bc != 8) $display("FAIL %s_busy_cycles: got %0d want 8", name, bc); else passed++;
        total++;
        if (bd !== 1'b0) $display("FAIL %s_busy_with_done: got %b want 0", name, bd); else passed++;
    endtask
    task automatic test_basic;
        run_and_check("basic", 8'h0D, 8'h0B);
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", bus.done); else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (bus.product !== 16'h008F) $display("FAIL basic_hold: got %h want 008f", bus.product); else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", bus.busy); else passed++;
    endtask
    task automatic test_full_range;
        run_and_check("full", 8'hFF, 8'hFF);
        run_and_check("rand", 8'($urandom), 8'($urandom));
    endtask
    task automatic test_zero;
        run_and_check("zero_a", 8'h00, 8'h37);
        run_and_check("zero_b", 8'h37, 8'h00);
    endtask
    task automatic test_busy_ignore;
        bit found;
        logic [15:0] got, exp;
        int bc, extra;
        logic bd;
        launch(8'h12, 8'h05, 1);
        @(negedge clk);
        bus.start = 1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        @(negedge clk);
        bus.start = 0;
        collect(found, got, bc, bd);
        exp = exp_q.pop_front();
        total++;
        if (!found || got !== exp) $display("FAIL ignore_product: got %h want %h", got, exp); else passed++;
        total++;
        if (bc != 6) $display("FAIL ignore_busy_after_pulse: got %0d want 6", bc); else passed++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        total++;
        if (extra != 0) $display("FAIL ignore_extra_done: got %0d want 0", extra); else passed++;
        total++;
        if (bus.product !== 16'h005A) $display("FAIL ignore_hold: got %h want 005a", bus.product); else passed++;
    endtask
    task automatic test_back_to_back;
        bit found;
        logic [15:0] got, exp;
        int bc;
        logic bd;
        launch(8'h11, 8'h11, 1);
        collect(found, got, bc, bd);
        exp = exp_q.pop_front();
        total++;
        if (!found || got !== exp) $display("FAIL b2b_first: got %h want %h", got, exp); else passed++;
        bus.start = 1;
        bus.a = 8'h80;
        bus.b = 8'h02;
        exp_q.push_back(16'h0100);
        @(negedge clk);
        bus.start = 0;
        total++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_no_idle: busy got %b want 1", bus.busy); else passed++;
        collect(found, got, bc, bd);
        exp = exp_q.pop_front();
        total++;
        if (!found || got !== exp) $display("FAIL b2b_second: got %h want %h", got, exp); else passed++;
        total++;
        if (bc != 8) $display("FAIL b2b_busy_cycles: got %0d want 8", bc); else passed++;
    endtask
    task automatic test_abort;
        int dones;
        launch(8'h55, 8'h66, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL abort_flags: busy %b done %b want 0 0", bus.busy, bus.done); else passed++;
        total++;
        if (bus.product !== 16'h0000) $display("FAIL abort_product: got %h want 0000", bus.product); else passed++;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        total++;
        if (dones != 0) $display("FAIL abort_done: got %0d pulses want 0", dones); else passed++;
        run_and_check("after_abort", 8'h03, 8'h07);
    endtask
    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_basic();
        test_full_range();
        test_zero();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
